// File: rtl/keypad_entry_buffer_pkg.sv
// keypad_pkg: shared constants, entry-state type and BCD helper for the
// keypad entry buffer.
//   KEY_STAR / KEY_HASH : special scanner keycodes
//   MAX_DIGITS          : BCD digits per entry
//   BCD_W / CNT_W       : entry value / digit-count widths
//   ENTRY_W             : width of one FIFO word {bcd, count}
//   BIN_W               : width of the binary conversion of an entry
// bcd_to_bin() is only called when KEYPAD_BIN_CONV_EN is defined.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR   = 4'd10;
  localparam logic [3:0] KEY_HASH   = 4'd11;
  localparam int         MAX_DIGITS = 4;
  localparam int         BCD_W      = 16;
  localparam int         CNT_W      = 3;
  localparam int         ENTRY_W    = BCD_W + CNT_W;
  localparam int         BIN_W      = 14;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULLENT = 2'd2
  } entry_state_t;

  // Four-digit BCD to binary: d3*1000 + d2*100 + d1*10 + d0 (max 9999).
  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [BCD_W-1:0] bcd);
    logic [BIN_W-1:0] d3;
    logic [BIN_W-1:0] d2;
    logic [BIN_W-1:0] d1;
    logic [BIN_W-1:0] d0;
    d3 = {10'd0, bcd[15:12]};
    d2 = {10'd0, bcd[11:8]};
    d1 = {10'd0, bcd[7:4]};
    d0 = {10'd0, bcd[3:0]};
    return d3 * 14'd1000 + d2 * 14'd100 + d1 * 14'd10 + d0;
  endfunction

endpackage

// File: rtl/keypad_entry_buffer_if.sv
// keypad_entry_buffer_if: committed-entry output stream.
//   out_valid  : FIFO head valid
//   out_ready  : consumer accepts the head
//   out_data   : head BCD value
//   out_ndig   : head digit count
//   bin_value  : binary value of the head (0 unless KEYPAD_BIN_CONV_EN)
// master = the buffer (producer), slave = the consumer.
interface keypad_entry_buffer_if;
  import keypad_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [BCD_W-1:0] out_data;
  logic [CNT_W-1:0] out_ndig;
  logic [BIN_W-1:0] bin_value;

  modport master (
    output out_valid,
    output out_data,
    output out_ndig,
    output bin_value,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ndig,
    input  bin_value,
    output out_ready
  );

endinterface

// File: rtl/keypad_entry_buffer_fifo.sv
// kpd_fifo: registered-storage FIFO for committed keypad entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and word (dropped if full with no pop)
//   pop        : read request (ignored when empty)
//   dout       : head word, read straight from the storage registers
//   empty,full : occupancy flags
// Pointers wrap modulo DEPTH (power of 2); count has log2(DEPTH)+1 bits
// so full and empty are distinct.
module kpd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO may still accept.
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer: assembles up to MAX_DIGITS BCD digits from keypad
// scanner events, commits them with '#', clears with '*', and queues
// committed entries in a FIFO.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   N, V                : scanner keycode and valid level
//   entry_bcd/entry_cnt : entry under construction (LS digit in [3:0])
//   ovf                 : sticky, digit arrived with the entry already full
//   err_full            : one-cycle pulse, '#' rejected because FIFO full
//   ob                  : committed-entry stream (keypad_entry_buffer_if)
// Optional feature: macro KEYPAD_BIN_CONV_EN enables the BCD-to-binary
// converter on ob.bin_value; undefined, bin_value is tied to 0.
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_DIGITS = keypad_pkg::MAX_DIGITS
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [3:0]           N,
  input  logic                 V,
  output logic [BCD_W-1:0]     entry_bcd,
  output logic [CNT_W-1:0]     entry_cnt,
  output logic                 ovf,
  output logic                 err_full,
  keypad_entry_buffer_if.master ob
);

  logic               v_q_r;
  entry_state_t       state_r;
  logic               key_ev_s;
  logic               is_digit_s;
  logic               is_star_s;
  logic               is_hash_s;
  logic               pop_s;
  logic               hash_commit_s;
  logic               push_s;
  logic               reject_s;
  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic [ENTRY_W-1:0] fifo_dout_s;

  // One event per press: rising edge of the held valid level.
  assign key_ev_s      = V & ~v_q_r;
  assign is_digit_s    = (N <= 4'd9);
  assign is_star_s     = (N == KEY_STAR);
  assign is_hash_s     = (N == KEY_HASH);
  assign pop_s         = ~fifo_empty_s & ob.out_ready;
  // '#' on an empty entry does nothing, so it never pushes or errors.
  assign hash_commit_s = key_ev_s & is_hash_s & (entry_cnt != {CNT_W{1'b0}});
  assign push_s        = hash_commit_s & (~fifo_full_s | pop_s);
  assign reject_s      = hash_commit_s & fifo_full_s & ~pop_s;

  kpd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push_s),
    .din   ({entry_bcd, entry_cnt}),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  assign ob.out_valid = ~fifo_empty_s;
  assign ob.out_data  = fifo_empty_s ? {BCD_W{1'b0}} : fifo_dout_s[ENTRY_W-1:CNT_W];
  assign ob.out_ndig  = fifo_empty_s ? {CNT_W{1'b0}} : fifo_dout_s[CNT_W-1:0];

`ifdef KEYPAD_BIN_CONV_EN
  assign ob.bin_value = ob.out_valid ? bcd_to_bin(ob.out_data) : {BIN_W{1'b0}};
`else
  assign ob.bin_value = {BIN_W{1'b0}};
`endif

  // Entry state machine with registered entry, overflow and error outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v_q_r     <= 1'b0;
      state_r   <= ST_EMPTY;
      entry_bcd <= {BCD_W{1'b0}};
      entry_cnt <= {CNT_W{1'b0}};
      ovf       <= 1'b0;
      err_full  <= 1'b0;
    end else begin
      v_q_r    <= V;
      err_full <= reject_s;
      if (key_ev_s) begin
        if (is_digit_s) begin
          case (state_r)
            ST_EMPTY, ST_PARTIAL: begin
              entry_bcd <= {entry_bcd[11:0], N};
              entry_cnt <= entry_cnt + 3'd1;
              state_r   <= (entry_cnt == CNT_W'(MAX_DIGITS - 1)) ? ST_FULLENT : ST_PARTIAL;
            end
            ST_FULLENT: begin
              ovf <= 1'b1;
            end
            default: begin
              // Unreachable encoding: recover to a clean empty entry.
              state_r   <= ST_EMPTY;
              entry_bcd <= {BCD_W{1'b0}};
              entry_cnt <= {CNT_W{1'b0}};
              ovf       <= 1'b0;
            end
          endcase
        end else if (is_star_s || push_s) begin
          state_r   <= ST_EMPTY;
          entry_bcd <= {BCD_W{1'b0}};
          entry_cnt <= {CNT_W{1'b0}};
          ovf       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Self-checking bench for keypad_entry_buffer: directed scenarios plus
// random key traffic, compared every cycle against a queue-based model.
module tb_keypad_entry_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  N;
  logic        V;
  logic [15:0] entry_bcd;
  logic [2:0]  entry_cnt;
  logic        ovf;
  logic        err_full;

  keypad_entry_buffer_if ifc ();

  keypad_entry_buffer #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .N         (N),
    .V         (V),
    .entry_bcd (entry_bcd),
    .entry_cnt (entry_cnt),
    .ovf       (ovf),
    .err_full  (err_full),
    .ob        (ifc)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] bcd;
    int          n;
    int          dec;
  } ent_t;

  int   ent[$];
  ent_t mfifo[$];
  bit   m_ovf;
  bit   m_err;
  bit   m_vq;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_bcd();
    int v = 0;
    foreach (ent[i]) v = v * 16 + ent[i];
    return 16'(v);
  endfunction

  task automatic model_reset();
    ent.delete();
    mfifo.delete();
    m_ovf = 1'b0;
    m_err = 1'b0;
    m_vq  = 1'b0;
  endtask

  task automatic model_edge();
    bit   ev;
    bit   pop;
    ent_t e;
    ev    = V && !m_vq;
    pop   = (mfifo.size() > 0) && ifc.out_ready;
    m_err = 1'b0;
    if (pop) void'(mfifo.pop_front());
    if (ev) begin
      if (N <= 4'd9) begin
        if (ent.size() < 4) ent.push_back(int'(N));
        else m_ovf = 1'b1;
      end else if (N == 4'd10) begin
        ent.delete();
        m_ovf = 1'b0;
      end else if (N == 4'd11 && ent.size() > 0) begin
        if (mfifo.size() < DEPTH) begin
          e.bcd = model_bcd();
          e.n   = ent.size();
          e.dec = 0;
          foreach (ent[i]) e.dec = e.dec * 10 + ent[i];
          mfifo.push_back(e);
          ent.delete();
          m_ovf = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    m_vq = V;
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      check("entry_bcd", 32'(entry_bcd), 32'(model_bcd()));
      check("entry_cnt", 32'(entry_cnt), ent.size());
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("err_full", 32'(err_full), 32'(m_err));
      check("out_valid", 32'(ifc.out_valid), 32'(mfifo.size() > 0));
      if (mfifo.size() > 0) begin
        check("out_data", 32'(ifc.out_data), 32'(mfifo[0].bcd));
        check("out_ndig", 32'(ifc.out_ndig), mfifo[0].n);
`ifdef KEYPAD_BIN_CONV_EN
        check("bin_value", 32'(ifc.bin_value), mfifo[0].dec);
`else
        check("bin_value", 32'(ifc.bin_value), 32'd0);
`endif
      end else begin
        check("out_data_idle", 32'(ifc.out_data), 32'd0);
        check("bin_idle", 32'(ifc.bin_value), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    N = k;
    V = 1'b1;
    repeat (hold) step();
    V = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_entry_bcd"}, 32'(entry_bcd), 32'd0);
    check({tag, "_entry_cnt"}, 32'(entry_cnt), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_err_full"}, 32'(err_full), 32'd0);
    check({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(ifc.out_data), 32'd0);
    check({tag, "_out_ndig"}, 32'(ifc.out_ndig), 32'd0);
    check({tag, "_bin_value"}, 32'(ifc.bin_value), 32'd0);
  endtask

  initial begin
    RST_N = 1'b1;
    N = 4'd0;
    V = 1'b0;
    ifc.out_ready = 1'b0;
    model_reset();
    #1 RST_N = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    chk_en = 1'b1;
    step();

    // 2,5,8,# each held 4 cycles.
    press(4'd2, 4);
    press(4'd5, 4);
    press(4'd8, 4);
    N = 4'd11;
    V = 1'b1;
    step();
    check("commit_latency_valid", 32'(ifc.out_valid), 32'd1);
    repeat (3) step();
    V = 1'b0;
    step();
    check("s1_out_data", 32'(ifc.out_data), 32'h0258);
    check("s1_out_ndig", 32'(ifc.out_ndig), 32'd3);
`ifdef KEYPAD_BIN_CONV_EN
    check("s1_bin_value", 32'(ifc.bin_value), 32'd258);
`else
    check("s1_bin_value", 32'(ifc.bin_value), 32'd0);
`endif
    ifc.out_ready = 1'b1;
    step();
    ifc.out_ready = 1'b0;
    check("s1_drained", 32'(ifc.out_valid), 32'd0);

    // Key 7 held 10 cycles counts once.
    press(4'd7, 10);
    check("hold_cnt", 32'(entry_cnt), 32'd1);
    check("hold_bcd", 32'(entry_bcd), 32'h0007);
    press(4'd10, 1);

    // Overflow then clear.
    press(4'd1, 2);
    press(4'd2, 2);
    press(4'd3, 2);
    press(4'd4, 2);
    press(4'd5, 2);
    check("ovf_bcd", 32'(entry_bcd), 32'h1234);
    check("ovf_set", 32'(ovf), 32'd1);
    press(4'd10, 2);
    check("star_bcd", 32'(entry_bcd), 32'd0);
    check("star_ovf", 32'(ovf), 32'd0);

    // Fill the FIFO with four "9#" and reject a fifth.
    for (int i = 0; i < 4; i++) begin
      press(4'd9, 2);
      press(4'd11, 2);
    end
    press(4'd9, 2);
    N = 4'd11;
    V = 1'b1;
    step();
    check("full_err_pulse", 32'(err_full), 32'd1);
    step();
    check("full_err_once", 32'(err_full), 32'd0);
    V = 1'b0;
    step();
    check("full_retained", 32'(entry_bcd), 32'h0009);

    // Same-edge push and pop on a full FIFO.
    press(4'd10, 1);
    press(4'd6, 1);
    N = 4'd11;
    V = 1'b1;
    ifc.out_ready = 1'b1;
    step();
    ifc.out_ready = 1'b0;
    check("pp_pushed", 32'(entry_cnt), 32'd0);
    V = 1'b0;
    step();
    press(4'd8, 1);
    N = 4'd11;
    V = 1'b1;
    step();
    check("pp_still_full", 32'(err_full), 32'd1);
    V = 1'b0;
    step();
    press(4'd10, 1);
    ifc.out_ready = 1'b1;
    repeat (3) step();
    check("pp_tail_data", 32'(ifc.out_data), 32'h0006);
    check("pp_tail_ndig", 32'(ifc.out_ndig), 32'd1);
    step();
    ifc.out_ready = 1'b0;
    check("pp_empty", 32'(ifc.out_valid), 32'd0);

    // Asynchronous reset mid-entry with a committed entry queued.
    press(4'd7, 1);
    press(4'd11, 1);
    press(4'd3, 1);
    press(4'd1, 1);
    check("pre_rst_bcd", 32'(entry_bcd), 32'h0031);
    check("pre_rst_valid", 32'(ifc.out_valid), 32'd1);
    N = 4'd5;
    V = 1'b1;
    #2 RST_N = 1'b0;
    model_reset();
    #1 check_all_zero("async_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    check("post_rst_cnt", 32'(entry_cnt), 32'd1);
    check("post_rst_bcd", 32'(entry_bcd), 32'h0005);
    V = 1'b0;
    step();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      ifc.out_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) V = ~V;
      if ($urandom_range(0, 3) == 0) N = 4'd11;
      else N = 4'($urandom_range(0, 15));
      step();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry_buffer.md
KEYPAD_ENTRY_BUFFER -- requirements
Module: keypad_entry_buffer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of committed entries held (power of 2, minimum 2).
REQ-002 The block SHALL have parameter MAX_DIGITS, fixed at 4, giving the number of BCD digits per entry.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low, on these ports:
- CLK  in  1  rising-edge clock, shared with the keypad scanner.
- RST_N  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these other ports:
- N  in  4  scanner keycode: 0-9 digits, 10 = '*', 11 = '#', 12-15 ignored.
- V  in  1  scanner valid level, high while a key is held.
- entry_bcd  out  16  digits being entered, least significant digit in [3:0].
- entry_cnt  out  3  digits entered, 0..4.
- ovf  out  1  sticky: a digit arrived while 4 digits were held.
- err_full  out  1  one-cycle pulse: '#' was rejected because the FIFO was full.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  16  head BCD value.
- out_ndig  out  3  head digit count.
- bin_value  out  14  binary value of the head (see Configuration).

Function
REQ-005 Key event: V=1 sampled while registered v_q=0 (one event per press; held keys and repeats are ignored); N is sampled on the same edge.
REQ-006 Entry state machine states: EMPTY (cnt 0), PARTIAL (cnt 1-3), FULLENT (cnt 4).
REQ-007 Digit event in EMPTY or PARTIAL: entry_bcd <= {entry_bcd[11:0], N}, cnt+1 on that edge; leads to PARTIAL, or FULLENT at cnt 4.
REQ-008 Digit event in FULLENT: entry unchanged; ovf <= 1.
REQ-009 '*' event in any state: entry_bcd <= 0, cnt <= 0, ovf <= 0; go to EMPTY.
REQ-010 '#' event in EMPTY: no action.
REQ-011 '#' event with cnt>0 and FIFO not full: push {entry_bcd, cnt}; clear the entry and ovf; go to EMPTY.
REQ-012 '#' event with the FIFO full and no pop on the same edge: entry retained; err_full=1 for exactly one cycle.
REQ-013 Same-edge '#' push and pop with the FIFO full: both SHALL succeed.
REQ-014 Keycodes 12-15 SHALL produce no action.
REQ-015 Pop on an edge with out_valid & out_ready; out_data and out_ndig show the head combinationally from the FIFO registers.
REQ-016 Push-to-out_valid latency SHALL be 1 cycle.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count is held in log2(FIFO_DEPTH)+1 bits.
REQ-018 Pop from an empty FIFO SHALL be ignored.

Reset
REQ-019 RST_N low SHALL asynchronously force the following, independent of CLK:
- entry_bcd=0, entry_cnt=0, ovf=0, err_full=0.
- out_valid=0, out_data=0, out_ndig=0, bin_value=0.
- v_q=0, FIFO empty, state EMPTY.
REQ-020 Reset mid-entry or mid-press SHALL discard the entry; a V level still high after release SHALL count as a new event.

Configuration
REQ-021 Macro KEYPAD_BIN_CONV_EN defined: bin_value = binary of out_data (d3*1000 + d2*100 + d1*10 + d0), combinational, 0 when out_valid=0.
REQ-022 Macro KEYPAD_BIN_CONV_EN undefined: bin_value tied to 0 and no converter logic is synthesized.

Structure
REQ-023 Package keypad_pkg SHALL hold:
- constants KEY_STAR=4'd10 and KEY_HASH=4'd11;
- MAX_DIGITS, BCD_W=16, CNT_W=3;
- the entry-state enum type.
REQ-024 The FIFO SHALL be sub-module kpd_fifo (parameterized depth and width 19, registered storage); all other logic stays in the top.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Keys 2,5,8,'#' each held 4 cycles -> out_valid next cycle; out_data=16'h0258, out_ndig=3, bin_value=258 with macro.
- Key 7 held 10 cycles -> entry_cnt=1 exactly; entry_bcd=16'h0007.
- Keys 1,2,3,4,5 -> entry_bcd=16'h1234, ovf=1; then '*' -> entry 0, ovf=0.
- out_ready=0, four commits of "9#" -> FIFO full; fifth "9#" -> err_full one-cycle pulse, entry_bcd=16'h0009 retained.
- FIFO full, '#' on the same edge as out_ready=1 -> push and pop both occur; count stays 4; head advances.
- RST_N low mid-entry (entry 16'h0031) -> all outputs 0 immediately, without a clock edge.
